pic_core_n: RTL and testbench
=============================

PIC_CORE_N -- requirements
Module: pic_core_n

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels; legal range 2..32.
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_IRQ), width of channel index.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq  input  NUM_IRQ  request lines, synchronous to clk.
REQ-006 SHALL have port wr_en  input  1  configuration write strobe, one cycle.
REQ-007 SHALL have port wr_addr  input  2  0=IMR, 1=trigger mode (1=level), 2=control (bit0 rotate, bit1 aeoi), 3=vector base (bits 7:0).
REQ-008 SHALL have port wr_data  input  32  write data; bits above NUM_IRQ-1 ignored for addr 0/1.
REQ-009 SHALL have ports eoi_valid  input  1, eoi_specific  input  1, eoi_id  input  ID_W: EOI command.
REQ-010 SHALL have port inta  input  1  acknowledge pulse, one cycle per pulse.
REQ-011 SHALL have port int_out  output  1  interrupt request to CPU, registered.
REQ-012 SHALL have ports vector_out  output  8 and vector_valid  output  1: vector delivery.
REQ-013 SHALL have port spurious  output  1  high with vector_valid when acknowledge found nothing pending.
REQ-014 SHALL have ports irr_out, isr_out, imr_out  output  NUM_IRQ  status registers.

Function
REQ-015 SHALL, in edge mode, set IRR[i] on a 0->1 transition of irq[i] versus the previous-cycle sample.
REQ-016 SHALL, in level mode, drive IRR[i] from irq[i] each cycle.
REQ-017 SHALL treat a channel as eligible when IRR=1, IMR=0, and it outranks every ISR bit set.
REQ-018 SHALL, when rotate=0, rank index 0 highest down to NUM_IRQ-1 lowest.
REQ-019 SHALL, when rotate=1, rank last_serviced+1 (mod NUM_IRQ) highest, ascending with wrap.
REQ-020 SHALL assert int_out one cycle after an eligible channel exists in state IDLE; deassert in ACK1.
REQ-021 SHALL implement states IDLE and ACK1; first inta: IDLE->ACK1; second inta: ACK1->IDLE.
REQ-022 SHALL, on first inta, latch winner id, set ISR[id], clear IRR[id] in edge mode.
REQ-023 SHALL, if no eligible channel at first inta, latch id NUM_IRQ-1, flag spurious, leave ISR/IRR unchanged.
REQ-024 SHALL, on second inta, pulse vector_valid one cycle next edge with vector_out = (base + id) mod 256.
REQ-025 SHALL, on second inta with aeoi=1 and not spurious, clear ISR[id]; with rotate=1 set last_serviced=id.
REQ-026 SHALL, on non-specific EOI, clear highest-ranked set ISR bit; with rotate=1 set last_serviced to it; no-op if ISR empty.
REQ-027 SHALL, on specific EOI, clear ISR[eoi_id]; ignore eoi_id >= NUM_IRQ; last_serviced unchanged.
REQ-028 SHALL let a new edge win over an IRR clear on the same channel in the same cycle.
REQ-029 SHALL apply an EOI and an AEOI clear in the same cycle both.
REQ-030 SHALL let config writes take effect next cycle; write during ACK1 does not change the latched id.
REQ-031 SHALL hold vector_out at last value when vector_valid=0.

Reset
REQ-032 SHALL on reset_n=0 immediately: state IDLE, IRR=0, ISR=0, IMR=all ones, trigger=all edge, rotate=0, aeoi=0, base=8'h20, last_serviced=NUM_IRQ-1.
REQ-033 SHALL on reset_n=0 immediately: int_out=0, vector_valid=0, spurious=0, vector_out=0, previous irq sample=0.
REQ-034 SHALL abandon an in-progress acknowledge on reset; next inta after release is a first inta.

Verification
REQ-035 SHALL cover: NUM_IRQ=8, IMR=0, edge irq[3]; two inta -> int_out=1, ISR=8'h08, vector_out=8'h23, IRR[3]=0.
REQ-036 SHALL cover: ISR[2] set, irq[5] pending -> int_out=0; irq[1] edge -> int_out=1, vector 8'h21.
REQ-037 SHALL cover: rotate=1, aeoi=1, irq[0] and irq[1] level held -> vectors 8'h20, 8'h21, 8'h20 alternate.
REQ-038 SHALL cover: irq pulse removed before first inta (level mode) -> vector 8'h27, spurious=1, ISR=0.
REQ-039 SHALL cover: ISR=8'h0C, non-specific EOI -> ISR=8'h08; specific EOI id 3 -> ISR=0; id 9 on NUM_IRQ=8 ignored.
REQ-040 SHALL cover: NUM_IRQ=32, base 8'hF0, channel 31 acknowledged -> vector_out=8'h0F; reset_n low in ACK1 -> IDLE, ISR=0.

Source files
------------

// File: rtl/pic_core_n.sv
// Programmable interrupt controller core: edge/level request capture, fixed or rotating
// priority, two-pulse acknowledge protocol, specific/non-specific/automatic EOI.
module pic_core_n #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               inta,
    output logic               int_out,
    output logic [7:0]         vector_out,
    output logic               vector_valid,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] irr_out,
    output logic [NUM_IRQ-1:0] isr_out,
    output logic [NUM_IRQ-1:0] imr_out
);

    typedef enum logic {S_IDLE, S_ACK1} state_t;

    localparam logic [NUM_IRQ-1:0] LSB_ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irr, r_isr, r_imr, r_trig, r_irqPrev;
    logic               r_rotate, r_aeoi;
    logic [7:0]         r_base;
    logic [ID_W-1:0]    r_last, r_id;
    logic               r_spur, r_int, r_vecValid, r_spurOut;
    logic [7:0]         r_vec;

    state_t             w_stateNext;
    logic               w_firstAck, w_secondAck, w_anyElig;
    logic [NUM_IRQ-1:0] w_req, w_winOh, w_eoiOh, w_edge, w_irrClr;
    logic [NUM_IRQ-1:0] w_eoiClr, w_aeoiClr, w_irrNext, w_isrNext;
    logic [ID_W-1:0]    w_winIdx, w_eoiIdx;
    logic [7:0]         w_vecNext;
    logic               w_unused;

    assign w_unused    = ^wr_data;
    assign w_req       = r_irr & ~r_imr;
    assign w_firstAck  = inta && (r_state == S_IDLE);
    assign w_secondAck = inta && (r_state == S_ACK1);

    // Walk channels from highest to lowest rank; the first in-service bit blocks everything below it.
    always_comb begin
        int   start;
        int   idx;
        logic blocked;
        logic found;
        logic eoiFound;
        logic [NUM_IRQ-1:0] mask;
        w_winOh   = '0;
        w_winIdx  = '0;
        w_eoiOh   = '0;
        w_eoiIdx  = '0;
        blocked   = 1'b0;
        found     = 1'b0;
        eoiFound  = 1'b0;
        start     = (r_rotate && (int'(r_last) != NUM_IRQ - 1)) ? int'(r_last) + 1 : 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            idx = start + k;
            if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
            mask = LSB_ONE << idx;
            if ((r_isr & mask) != '0) begin
                if (!eoiFound) begin
                    w_eoiOh  = mask;
                    w_eoiIdx = ID_W'(idx);
                    eoiFound = 1'b1;
                end
                blocked = 1'b1;
            end
            if (!blocked && !found && ((w_req & mask) != '0)) begin
                w_winOh  = mask;
                w_winIdx = ID_W'(idx);
                found    = 1'b1;
            end
        end
        w_anyElig = found;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (inta) w_stateNext = S_ACK1;
            S_ACK1: if (inta) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // A fresh edge on a channel outranks the acknowledge clearing that same channel.
    always_comb begin
        w_edge    = irq & ~r_irqPrev;
        w_irrClr  = (w_firstAck && w_anyElig) ? w_winOh : '0;
        w_irrNext = (r_trig & irq) | (~r_trig & (w_edge | (r_irr & ~w_irrClr)));
        w_eoiClr  = '0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (int'(eoi_id) < NUM_IRQ) w_eoiClr = LSB_ONE << eoi_id;
            end else begin
                w_eoiClr = w_eoiOh;
            end
        end
        w_aeoiClr = (w_secondAck && r_aeoi && !r_spur) ? (LSB_ONE << r_id) : '0;
        w_isrNext = (r_isr & ~w_eoiClr & ~w_aeoiClr) | w_irrClr;
        w_vecNext = r_base + 8'(r_id);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_irr      <= '0;
            r_isr      <= '0;
            r_imr      <= '1;
            r_trig     <= '0;
            r_irqPrev  <= '0;
            r_rotate   <= 1'b0;
            r_aeoi     <= 1'b0;
            r_base     <= 8'h20;
            r_last     <= ID_W'(NUM_IRQ - 1);
            r_id       <= '0;
            r_spur     <= 1'b0;
            r_int      <= 1'b0;
            r_vec      <= 8'h00;
            r_vecValid <= 1'b0;
            r_spurOut  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_irqPrev  <= irq;
            r_irr      <= w_irrNext;
            r_isr      <= w_isrNext;
            r_int      <= (w_stateNext == S_IDLE) && w_anyElig;
            r_vecValid <= w_secondAck;
            r_spurOut  <= w_secondAck && r_spur;
            if (w_secondAck) r_vec <= w_vecNext;
            if (w_firstAck) begin
                r_id   <= w_anyElig ? w_winIdx : ID_W'(NUM_IRQ - 1);
                r_spur <= !w_anyElig;
            end
            if (eoi_valid && !eoi_specific && r_rotate && (w_eoiOh != '0)) r_last <= w_eoiIdx;
            if (w_secondAck && r_aeoi && !r_spur && r_rotate) r_last <= r_id;
            if (wr_en) begin
                case (wr_addr)
                    2'd0: r_imr  <= wr_data[NUM_IRQ-1:0];
                    2'd1: r_trig <= wr_data[NUM_IRQ-1:0];
                    2'd2: begin
                        r_rotate <= wr_data[0];
                        r_aeoi   <= wr_data[1];
                    end
                    default: r_base <= wr_data[7:0];
                endcase
            end
        end
    end

    assign int_out      = r_int;
    assign vector_out   = r_vec;
    assign vector_valid = r_vecValid;
    assign spurious     = r_spurOut;
    assign irr_out      = r_irr;
    assign isr_out      = r_isr;
    assign imr_out      = r_imr;

endmodule

// File: tb/tb_pic_core_n.sv
// Directed bench for pic_core_n: an 8-channel instance (4-bit EOI id so out-of-range ids
// can be driven) and a 32-channel instance sharing the control strobes.
module tb_pic_core_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  irq8;
    logic [31:0] irq32;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        eoi_valid, eoi_specific, inta;
    logic [3:0]  eoi_id8;
    logic [4:0]  eoi_id32;

    logic        int8, vvalid8, spur8;
    logic [7:0]  vec8, irr8, isr8, imr8;
    logic        int32, vvalid32, spur32;
    logic [7:0]  vec32;
    logic [31:0] irr32, isr32, imr32;

    int checkCount = 0;
    int errorCount = 0;
    logic [7:0] rotVec [3];

    pic_core_n #(.NUM_IRQ(8), .ID_W(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .irq(irq8), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_id(eoi_id8), .inta(inta), .int_out(int8), .vector_out(vec8),
        .vector_valid(vvalid8), .spurious(spur8), .irr_out(irr8), .isr_out(isr8),
        .imr_out(imr8)
    );

    pic_core_n #(.NUM_IRQ(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .irq(irq32), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_id(eoi_id32), .inta(inta), .int_out(int32), .vector_out(vec32),
        .vector_valid(vvalid32), .spurious(spur32), .irr_out(irr32), .isr_out(isr32),
        .imr_out(imr32)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of control strobes starting at a falling edge, then return them to idle.
    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] data,
                                 input logic ack, input logic eoiV, input logic eoiS,
                                 input logic [4:0] id);
        wr_en        = we;
        wr_addr      = addr;
        wr_data      = data;
        inta         = ack;
        eoi_valid    = eoiV;
        eoi_specific = eoiS;
        eoi_id8      = id[3:0];
        eoi_id32     = id;
        @(negedge clk);
        wr_en        = 1'b0;
        wr_addr      = 2'd0;
        wr_data      = 32'd0;
        inta         = 1'b0;
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_id8      = 4'd0;
        eoi_id32     = 5'd0;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic ack();
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic eoiNonSpecific();
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    endtask

    task automatic eoiSpecific(input logic [4:0] id);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, id);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        irq8 = '0; irq32 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id8 = '0; eoi_id32 = '0;
        inta = 1'b0;
        rotVec[0] = 8'h20; rotVec[1] = 8'h21; rotVec[2] = 8'h20;
        #12;
        checkOutput("rst_int", {31'd0, int8}, 32'd0);
        checkOutput("rst_imr", {24'd0, imr8}, 32'h0000_00FF);
        checkOutput("rst_irr_isr", {16'd0, irr8, isr8}, 32'd0);
        checkOutput("rst_vec", {22'd0, vvalid8, spur8, vec8}, 32'd0);
        checkOutput("rst_imr32", imr32, 32'hFFFF_FFFF);
        @(negedge clk);
        reset_n = 1'b1;

        // Edge-triggered channel 3, full acknowledge
        writeReg(2'd0, 32'd0);
        checkOutput("imr_write", {24'd0, imr8}, 32'd0);
        irq8 = 8'h08;
        waitCycles(1);
        checkOutput("edge_irr", {24'd0, irr8}, 32'h08);
        waitCycles(1);
        checkOutput("edge_int", {31'd0, int8}, 32'd1);
        ack();
        checkOutput("ack1_isr", {24'd0, isr8}, 32'h08);
        checkOutput("ack1_irr", {24'd0, irr8}, 32'h00);
        checkOutput("ack1_int", {31'd0, int8}, 32'd0);
        ack();
        checkOutput("ack2_valid", {31'd0, vvalid8}, 32'd1);
        checkOutput("ack2_vec", {24'd0, vec8}, 32'h23);
        checkOutput("ack2_spur", {31'd0, spur8}, 32'd0);
        waitCycles(1);
        checkOutput("vec_hold", {23'd0, vvalid8, vec8}, 32'h023);
        irq8 = 8'h00;
        eoiNonSpecific();
        checkOutput("eoi_clear", {24'd0, isr8}, 32'h00);

        // In-service channel 2 blocks lower channel 5, not higher channel 1
        irq8 = 8'h04;
        waitCycles(2);
        ack(); ack();
        checkOutput("ch2_vec", {24'd0, vec8}, 32'h22);
        irq8 = 8'h24;
        waitCycles(2);
        checkOutput("ch5_irr", {24'd0, irr8}, 32'h20);
        checkOutput("ch5_blocked", {31'd0, int8}, 32'd0);
        irq8 = 8'h26;
        waitCycles(2);
        checkOutput("ch1_int", {31'd0, int8}, 32'd1);
        ack(); ack();
        checkOutput("ch1_vec", {24'd0, vec8}, 32'h21);
        checkOutput("ch1_isr", {24'd0, isr8}, 32'h06);
        irq8 = 8'h00;
        eoiNonSpecific();
        checkOutput("ns_eoi_06", {24'd0, isr8}, 32'h04);
        eoiNonSpecific();
        waitCycles(1);
        checkOutput("ch5_unblocked", {31'd0, int8}, 32'd1);
        ack(); ack();
        checkOutput("ch5_vec", {24'd0, vec8}, 32'h25);
        eoiNonSpecific();

        // EOI variants on ISR = 0x0C
        irq8 = 8'h08;
        waitCycles(2);
        ack(); ack();
        irq8 = 8'h0C;
        waitCycles(2);
        ack(); ack();
        checkOutput("nest_vec", {24'd0, vec8}, 32'h22);
        checkOutput("nest_isr", {24'd0, isr8}, 32'h0C);
        eoiNonSpecific();
        checkOutput("ns_eoi_0c", {24'd0, isr8}, 32'h08);
        eoiSpecific(5'd9);
        checkOutput("spec_eoi_9", {24'd0, isr8}, 32'h08);
        eoiSpecific(5'd3);
        checkOutput("spec_eoi_3", {24'd0, isr8}, 32'h00);
        irq8 = 8'h00;

        // Level pulse withdrawn before acknowledge gives a spurious vector
        writeReg(2'd1, 32'h0000_00FF);
        irq8 = 8'h10;
        waitCycles(2);
        checkOutput("lvl_irr", {24'd0, irr8}, 32'h10);
        checkOutput("lvl_int", {31'd0, int8}, 32'd1);
        irq8 = 8'h00;
        waitCycles(1);
        ack(); ack();
        checkOutput("spur_valid", {31'd0, vvalid8}, 32'd1);
        checkOutput("spur_flag", {31'd0, spur8}, 32'd1);
        checkOutput("spur_vec", {24'd0, vec8}, 32'h27);
        checkOutput("spur_isr", {24'd0, isr8}, 32'h00);

        // Rotating priority with automatic EOI on two held level requests
        writeReg(2'd2, 32'h0000_0003);
        irq8 = 8'h03;
        waitCycles(2);
        for (int i = 0; i < 3; i++) begin
            ack(); ack();
            checkOutput($sformatf("rot_vec%0d", i), {23'd0, vvalid8, vec8}, {23'd0, 1'b1, rotVec[i]});
        end
        checkOutput("rot_isr", {24'd0, isr8}, 32'h00);
        irq8 = 8'h00;

        // 32-channel instance: vector wrap, reset during acknowledge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rst32_vec", {24'd0, vec32}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        writeReg(2'd0, 32'd0);
        writeReg(2'd3, 32'h0000_00F0);
        irq32 = 32'h8000_0000;
        waitCycles(2);
        checkOutput("c31_int", {31'd0, int32}, 32'd1);
        ack(); ack();
        checkOutput("c31_vec", {23'd0, vvalid32, vec32}, 32'h10F);
        checkOutput("c31_isr", isr32, 32'h8000_0000);
        irq32 = 32'h8000_0001;
        waitCycles(2);
        checkOutput("c0_int", {31'd0, int32}, 32'd1);
        ack();
        checkOutput("c0_ack1_isr", isr32, 32'h8000_0001);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_isr", isr32, 32'd0);
        checkOutput("mid_rst_out", {30'd0, int32, vvalid32}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        writeReg(2'd0, 32'd0);
        waitCycles(1);
        checkOutput("post_rst_int", {31'd0, int32}, 32'd1);
        ack();
        checkOutput("post_rst_isr", isr32, 32'h0000_0001);
        checkOutput("post_rst_first", {31'd0, vvalid32}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
